// File: rtl/adder_error_monitor.sv
// adder_error_monitor: accumulates error-distance statistics of an approximate 8-bit adder against the exact result
module adder_error_monitor #(
  parameter int NUM_SAMPLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  exact_sum,
  input  logic [8:0]  approx_sum,
  output logic [15:0] sample_count,
  output logic [15:0] err_count,
  output logic [31:0] ed_sum,
  output logic [8:0]  ed_max,
  output logic        busy,
  output logic        done
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [15:0] LAST = 16'(NUM_SAMPLES - 1);
  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d, err_q, err_d;
  logic [31:0] sum_q, sum_d;
  logic [8:0]  max_q, max_d, ed;
  logic [32:0] sum_wide;
  logic        go, accept;
  always_comb begin
    ed       = exact_sum >= approx_sum ? exact_sum - approx_sum : approx_sum - exact_sum;
    go       = start && state_q != RUN;
    accept   = in_valid && state_q == RUN;
    sum_wide = {1'b0, sum_q} + 33'(ed);
    state_d  = go ? RUN : (accept && cnt_q == LAST) ? DONE : state_q;
    cnt_d    = go ? '0 : accept ? cnt_q + 16'd1 : cnt_q;
    err_d    = go ? '0 : (accept && ed != '0) ? err_q + 16'd1 : err_q;
    sum_d    = go ? '0 : accept ? (sum_wide[32] ? '1 : sum_wide[31:0]) : sum_q;
    max_d    = go ? '0 : (accept && ed > max_q) ? ed : max_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
      sum_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
    end
  end
  assign in_ready     = state_q == RUN;
  assign busy         = state_q == RUN;
  assign done         = state_q == DONE;
  assign sample_count = cnt_q;
  assign err_count    = err_q;
  assign ed_sum       = sum_q;
  assign ed_max       = max_q;
endmodule

// File: tb/tb_adder_error_monitor.sv
// tb_adder_error_monitor: directed checks of the error monitor with NUM_SAMPLES=4
module tb_adder_error_monitor;
  logic        clk, rst, start, in_valid, in_ready, busy, done;
  logic [8:0]  exact_sum, approx_sum, ed_max;
  logic [15:0] sample_count, err_count;
  logic [31:0] ed_sum;
  int n_cmp = 0;
  int n_bad = 0;
  adder_error_monitor #(.NUM_SAMPLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .exact_sum(exact_sum), .approx_sum(approx_sum), .sample_count(sample_count),
    .err_count(err_count), .ed_sum(ed_sum), .ed_max(ed_max), .busy(busy), .done(done)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic stats(input string tag, input int c, input int e, input int s, input int m, input int b, input int d);
    check({tag, ".count"}, 32'(sample_count), 32'(c));
    check({tag, ".err"}, 32'(err_count), 32'(e));
    check({tag, ".sum"}, ed_sum, 32'(s));
    check({tag, ".max"}, 32'(ed_max), 32'(m));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".ready"}, 32'(in_ready), 32'(b));
    check({tag, ".done"}, 32'(done), 32'(d));
  endtask
  task automatic pulse_start(input logic v);
    start = 1; in_valid = v;
    @(negedge clk);
    start = 0; in_valid = 0;
  endtask
  task automatic send(input int e, input int a);
    exact_sum = 9'(e); approx_sum = 9'(a); in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask
  initial begin
    rst = 1; start = 0; in_valid = 0; exact_sum = 0; approx_sum = 0;
    #2;
    stats("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 0;
    exact_sum = 0; approx_sum = 511; in_valid = 1;
    idle(5);
    in_valid = 0;
    stats("idle_valid", 0, 0, 0, 0, 0, 0);
    pulse_start(0);
    stats("started", 0, 0, 0, 0, 1, 0);
    send(100, 100); send(200, 198);
    stats("two", 2, 1, 2, 2, 1, 0);
    send(50, 60); send(511, 0);
    stats("run1", 4, 3, 523, 511, 0, 1);
    send(7, 0); idle(2);
    stats("done_hold", 4, 3, 523, 511, 0, 1);
    exact_sum = 0; approx_sum = 511;
    pulse_start(1);
    stats("restart_valid", 0, 0, 0, 0, 1, 0);
    exact_sum = 10; approx_sum = 12;
    send(10, 12); idle(2); send(10, 12); send(10, 12); idle(1);
    stats("gaps3", 3, 3, 6, 2, 1, 0);
    send(10, 12);
    stats("gaps4", 4, 4, 8, 2, 0, 1);
    pulse_start(0);
    send(100, 100); send(200, 198);
    #2 rst = 1;
    #1 stats("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 0;
    idle(2);
    stats("post_rst", 0, 0, 0, 0, 0, 0);
    pulse_start(0);
    send(100, 100); send(200, 198); send(50, 60); send(511, 0);
    stats("run_after_rst", 4, 3, 523, 511, 0, 1);
    pulse_start(0);
    send(100, 100); send(200, 198);
    pulse_start(0);
    stats("mid_start", 2, 1, 2, 2, 1, 0);
    send(50, 60); send(511, 0);
    stats("run_mid_start", 4, 3, 523, 511, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
